// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one Hack ALU; IDLE -> EXEC -> HOLD per operation.
// Define ALU_ARBITER_FLAGS_EN to add registered zero/negative flags (o_Rsp_ZR, o_Rsp_NG).
module alu_arbiter (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Req0_Valid,
    output logic        o_Req0_Ready,
    input  logic [15:0] i_Req0_X,
    input  logic [15:0] i_Req0_Y,
    input  logic [5:0]  i_Req0_Ctl,
    input  logic        i_Req1_Valid,
    output logic        o_Req1_Ready,
    input  logic [15:0] i_Req1_X,
    input  logic [15:0] i_Req1_Y,
    input  logic [5:0]  i_Req1_Ctl,
    output logic        o_Rsp_Valid,
    input  logic        i_Rsp_Ready,
    output logic        o_Rsp_Id,
    output logic [15:0] o_Rsp_Data,
    output logic        o_Busy
`ifdef ALU_ARBITER_FLAGS_EN
    ,
    output logic        o_Rsp_ZR,
    output logic        o_Rsp_NG
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic        ptr;
    logic [15:0] op_x;
    logic [15:0] op_y;
    logic [5:0]  op_ctl;
    logic        op_id;

    logic        grant0;
    logic        grant1;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_f;
    logic [15:0] alu_out;

    // Ready is gated by reset so neither requester can see a grant while the block is held in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && i_Rst_n) begin
            if (i_Req0_Valid && (!i_Req1_Valid || !ptr))
                grant0 = 1'b1;
            else if (i_Req1_Valid)
                grant1 = 1'b1;
        end
    end

    assign o_Req0_Ready = grant0;
    assign o_Req1_Ready = grant1;
    assign o_Busy       = (state != IDLE);

    always_comb begin
        alu_x   = op_ctl[5] ? 16'h0000 : op_x;
        alu_x   = op_ctl[4] ? ~alu_x : alu_x;
        alu_y   = op_ctl[3] ? 16'h0000 : op_y;
        alu_y   = op_ctl[2] ? ~alu_y : alu_y;
        alu_f   = op_ctl[1] ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out = op_ctl[0] ? ~alu_f : alu_f;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            op_x        <= 16'h0000;
            op_y        <= 16'h0000;
            op_ctl      <= 6'd0;
            op_id       <= 1'b0;
            o_Rsp_Valid <= 1'b0;
            o_Rsp_Id    <= 1'b0;
            o_Rsp_Data  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_x   <= grant1 ? i_Req1_X   : i_Req0_X;
                        op_y   <= grant1 ? i_Req1_Y   : i_Req0_Y;
                        op_ctl <= grant1 ? i_Req1_Ctl : i_Req0_Ctl;
                        op_id  <= grant1;
                        ptr    <= grant0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    o_Rsp_Data  <= alu_out;
                    o_Rsp_Id    <= op_id;
                    o_Rsp_Valid <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (i_Rsp_Ready) begin
                        o_Rsp_Valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_Rsp_Valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARBITER_FLAGS_EN
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Rsp_ZR <= 1'b0;
            o_Rsp_NG <= 1'b0;
        end else if (state == EXEC) begin
            o_Rsp_ZR <= (alu_out == 16'h0000);
            o_Rsp_NG <= alu_out[15];
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: grants push hand-computed expectations, a monitor pops them on each response.
module tb_alu_arbiter;

    logic        i_Clk;
    logic        i_Rst_n;
    logic        i_Req0_Valid;
    logic        o_Req0_Ready;
    logic [15:0] i_Req0_X;
    logic [15:0] i_Req0_Y;
    logic [5:0]  i_Req0_Ctl;
    logic        i_Req1_Valid;
    logic        o_Req1_Ready;
    logic [15:0] i_Req1_X;
    logic [15:0] i_Req1_Y;
    logic [5:0]  i_Req1_Ctl;
    logic        o_Rsp_Valid;
    logic        i_Rsp_Ready;
    logic        o_Rsp_Id;
    logic [15:0] o_Rsp_Data;
    logic        o_Busy;
`ifdef ALU_ARBITER_FLAGS_EN
    logic        o_Rsp_ZR;
    logic        o_Rsp_NG;
`endif

    alu_arbiter dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Req0_Valid (i_Req0_Valid),
        .o_Req0_Ready (o_Req0_Ready),
        .i_Req0_X     (i_Req0_X),
        .i_Req0_Y     (i_Req0_Y),
        .i_Req0_Ctl   (i_Req0_Ctl),
        .i_Req1_Valid (i_Req1_Valid),
        .o_Req1_Ready (o_Req1_Ready),
        .i_Req1_X     (i_Req1_X),
        .i_Req1_Y     (i_Req1_Y),
        .i_Req1_Ctl   (i_Req1_Ctl),
        .o_Rsp_Valid  (o_Rsp_Valid),
        .i_Rsp_Ready  (i_Rsp_Ready),
        .o_Rsp_Id     (o_Rsp_Id),
        .o_Rsp_Data   (o_Rsp_Data),
        .o_Busy       (o_Busy)
`ifdef ALU_ARBITER_FLAGS_EN
        ,
        .o_Rsp_ZR     (o_Rsp_ZR),
        .o_Rsp_NG     (o_Rsp_NG)
`endif
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctl;
        logic [15:0] data;
        logic        zr;
        logic        ng;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        zr;
        logic        ng;
    } exp_t;

    vec_t v0 [0:7];
    vec_t v1 [0:7];
    vec_t cur0;
    vec_t cur1;
    exp_t sb [$];
    logic grant_log [$];

    int total = 0;
    int bad   = 0;

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic [5:0] ctl,
                                input logic [15:0] data, input logic zr, input logic ng);
        vec_t v;
        v.x = x; v.y = y; v.ctl = ctl; v.data = data; v.zr = zr; v.ng = ng;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grants push the expected response; handshakes pop and compare it.
    always @(negedge i_Clk) begin
        exp_t e;
        if (o_Rsp_Valid && i_Rsp_Ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_id", {31'd0, o_Rsp_Id}, {31'd0, e.id});
                checkOutput("rsp_data", {16'd0, o_Rsp_Data}, {16'd0, e.data});
`ifdef ALU_ARBITER_FLAGS_EN
                checkOutput("rsp_zr", {31'd0, o_Rsp_ZR}, {31'd0, e.zr});
                checkOutput("rsp_ng", {31'd0, o_Rsp_NG}, {31'd0, e.ng});
`endif
            end
        end
        if (o_Req0_Ready || o_Req1_Ready) begin
            checkOutput("ready_exclusive", {31'd0, o_Req0_Ready & o_Req1_Ready}, 32'd0);
            if (o_Req0_Ready && i_Req0_Valid) begin
                e.id = 1'b0; e.data = cur0.data; e.zr = cur0.zr; e.ng = cur0.ng;
                sb.push_back(e);
                grant_log.push_back(1'b0);
            end
            if (o_Req1_Ready && i_Req1_Valid) begin
                e.id = 1'b1; e.data = cur1.data; e.zr = cur1.zr; e.ng = cur1.ng;
                sb.push_back(e);
                grant_log.push_back(1'b1);
            end
        end
    end

    // Presents `count` vectors back to back, holding Valid until each is accepted.
    task automatic applyStimulus(input int req, input int first, input int count);
        for (int k = 0; k < count; k++) begin
            int budget;
            bit accepted;
            if (req == 0) begin
                cur0 = v0[first + k];
                i_Req0_X = cur0.x; i_Req0_Y = cur0.y; i_Req0_Ctl = cur0.ctl;
                i_Req0_Valid = 1'b1;
            end else begin
                cur1 = v1[first + k];
                i_Req1_X = cur1.x; i_Req1_Y = cur1.y; i_Req1_Ctl = cur1.ctl;
                i_Req1_Valid = 1'b1;
            end
            budget = 0;
            accepted = 1'b0;
            while (!accepted && budget < 200) begin
                @(negedge i_Clk);
                budget++;
                if ((req == 0 && o_Req0_Ready) || (req == 1 && o_Req1_Ready))
                    accepted = 1'b1;
            end
            if (!accepted)
                checkOutput("req_timeout", 32'd0, 32'd1);
            @(posedge i_Clk);
            #1;
        end
        if (req == 0) i_Req0_Valid = 1'b0;
        else          i_Req1_Valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(negedge i_Clk);
            budget++;
        end
        checkOutput("drain", sb.size(), 32'd0);
        @(posedge i_Clk);
        #1;
    endtask

    task automatic waitRspValid();
        int budget = 0;
        while (!o_Rsp_Valid && budget < 20) begin
            @(negedge i_Clk);
            budget++;
        end
        checkOutput("rsp_valid_seen", {31'd0, o_Rsp_Valid}, 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, o_Rsp_Valid}, 32'd0);
        checkOutput({tag, "_id"}, {31'd0, o_Rsp_Id}, 32'd0);
        checkOutput({tag, "_data"}, {16'd0, o_Rsp_Data}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, o_Busy}, 32'd0);
        checkOutput({tag, "_ready0"}, {31'd0, o_Req0_Ready}, 32'd0);
        checkOutput({tag, "_ready1"}, {31'd0, o_Req1_Ready}, 32'd0);
`ifdef ALU_ARBITER_FLAGS_EN
        checkOutput({tag, "_zr"}, {31'd0, o_Rsp_ZR}, 32'd0);
        checkOutput({tag, "_ng"}, {31'd0, o_Rsp_NG}, 32'd0);
`endif
    endtask

    task automatic pulseReset();
        @(posedge i_Clk);
        #3;
        i_Rst_n = 1'b0;
        sb.delete();
        #1;
        checkResetState("mid_reset");
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        int seen;
        v0[0] = mk(16'd5,    16'd3,    6'b000010, 16'h0008, 1'b0, 1'b0);
        v0[1] = mk(16'd1,    16'd1,    6'b000010, 16'h0002, 1'b0, 1'b0);
        v0[2] = mk(16'h1234, 16'h0F0F, 6'b000000, 16'h0204, 1'b0, 1'b0);
        v0[3] = mk(16'hAAAA, 16'h5555, 6'b000010, 16'hFFFF, 1'b0, 1'b1);
        v0[4] = mk(16'd1,    16'd2,    6'b000010, 16'h0003, 1'b0, 1'b0);
        v0[5] = mk(16'd1,    16'd1,    6'b000010, 16'h0002, 1'b0, 1'b0);
        v0[6] = mk(16'd2,    16'd2,    6'b000010, 16'h0004, 1'b0, 1'b0);
        v0[7] = mk(16'hFFFF, 16'd1,    6'b000010, 16'h0000, 1'b1, 1'b0);
        v1[0] = mk(16'h00F0, 16'h0FF0, 6'b000000, 16'h00F0, 1'b0, 1'b0);
        v1[1] = mk(16'd3,    16'd5,    6'b010011, 16'hFFFE, 1'b0, 1'b1);
        v1[2] = mk(16'd3,    16'd5,    6'b101010, 16'h0000, 1'b1, 1'b0);
        v1[3] = mk(16'd7,    16'd1,    6'b000010, 16'h0008, 1'b0, 1'b0);
        v1[4] = mk(16'h0100, 16'h0100, 6'b000000, 16'h0100, 1'b0, 1'b0);
        v1[5] = mk(16'hF0F0, 16'hFF00, 6'b000000, 16'hF000, 1'b0, 1'b1);
        v1[6] = mk(16'd3,    16'd5,    6'b010011, 16'hFFFE, 1'b0, 1'b1);
        v1[7] = mk(16'd0,    16'd0,    6'b111111, 16'h0001, 1'b0, 1'b0);

        i_Rst_n = 1'b0;
        i_Rsp_Ready = 1'b1;
        i_Req1_Valid = 1'b0; i_Req1_X = 16'h0; i_Req1_Y = 16'h0; i_Req1_Ctl = 6'd0;
        cur0 = v0[0];
        cur1 = v1[0];
        i_Req0_X = v0[0].x; i_Req0_Y = v0[0].y; i_Req0_Ctl = v0[0].ctl;
        i_Req0_Valid = 1'b1;
        repeat (2) @(posedge i_Clk);
        #1;
        $display("[TB] reset state");
        checkResetState("reset");
        i_Req0_Valid = 1'b0;
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;

        $display("[TB] single op and latency");
        applyStimulus(0, 0, 1);
        checkOutput("lat_exec_valid", {31'd0, o_Rsp_Valid}, 32'd0);
        checkOutput("lat_exec_busy", {31'd0, o_Busy}, 32'd1);
        @(posedge i_Clk);
        #1;
        checkOutput("lat_hold_valid", {31'd0, o_Rsp_Valid}, 32'd1);
        drain();

        $display("[TB] simultaneous requests after reset");
        pulseReset();
        grant_log.delete();
        fork
            applyStimulus(0, 1, 1);
            applyStimulus(1, 0, 1);
        join
        drain();
        checkOutput("rr_count", grant_log.size(), 32'd2);
        if (grant_log.size() == 2) begin
            checkOutput("rr_first", {31'd0, grant_log[0]}, 32'd0);
            checkOutput("rr_second", {31'd0, grant_log[1]}, 32'd1);
        end

        $display("[TB] subtract and zero results");
        applyStimulus(1, 1, 2);
        drain();

        $display("[TB] consumer stall");
        i_Rsp_Ready = 1'b0;
        applyStimulus(0, 2, 1);
        waitRspValid();
        fork
            applyStimulus(1, 3, 1);
        join_none
        for (int c = 0; c < 10; c++) begin
            @(negedge i_Clk);
            checkOutput("stall_valid", {31'd0, o_Rsp_Valid}, 32'd1);
            checkOutput("stall_data", {16'd0, o_Rsp_Data}, 32'h0204);
            checkOutput("stall_id", {31'd0, o_Rsp_Id}, 32'd0);
            checkOutput("stall_ready0", {31'd0, o_Req0_Ready}, 32'd0);
            checkOutput("stall_ready1", {31'd0, o_Req1_Ready}, 32'd0);
            checkOutput("stall_busy", {31'd0, o_Busy}, 32'd1);
        end
        @(posedge i_Clk);
        #1;
        i_Rsp_Ready = 1'b1;
        wait fork;
        drain();

        $display("[TB] reset while holding a result");
        i_Rsp_Ready = 1'b0;
        applyStimulus(0, 3, 1);
        waitRspValid();
        pulseReset();
        i_Rsp_Ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_Clk);
            if (o_Rsp_Valid) seen++;
        end
        checkOutput("no_rsp_after_reset", seen, 32'd0);
        @(posedge i_Clk);
        #1;
        grant_log.delete();
        fork
            applyStimulus(0, 4, 1);
            applyStimulus(1, 4, 1);
        join
        drain();
        checkOutput("ptr_reset_count", grant_log.size(), 32'd2);
        if (grant_log.size() == 2)
            checkOutput("ptr_reset_first", {31'd0, grant_log[0]}, 32'd0);

        $display("[TB] continuous contention");
        grant_log.delete();
        fork
            applyStimulus(0, 5, 3);
            applyStimulus(1, 5, 3);
        join
        drain();
        checkOutput("alt_count", grant_log.size(), 32'd6);
        for (int g = 0; g < grant_log.size() && g < 6; g++)
            checkOutput("alt_grant", {31'd0, grant_log[g]}, g % 2);

        repeat (3) @(posedge i_Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
